// File: rtl/wishbone_rr_arbiter.sv
// wishbone_rr_arbiter
// Shares one Wishbone B4 slave port between NUM_M masters using round-robin
// arbitration on CYC. A grant is held for the whole cycle/burst and extended
// while the owner keeps LOCK asserted. A per-grant watchdog terminates a
// stalled strobe with ERR so a hung slave cannot hold the bus forever.
//
// Ports:
//   CLK_I, RST_I          clock, asynchronous active-low reset
//   M_*_I                 per-master request signals, packed (master i at [i*W +: W])
//   M_DAT_O               slave read data, broadcast to every master
//   M_ACK/ERR/RTY_O       per-master terminations, only the owner ever sees them
//   S_*_O / S_*_I         the single shared slave port
//   grant_o               one-hot current owner (zero when idle)
//   timeout_o             one-cycle pulse when the watchdog terminates a transfer
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no owner, slave port quiet, arbitrating among CYC requests
// ST_GRANT   | ptr_q owns the slave port, signals muxed through
// ST_TIMEOUT | watchdog fired: one-cycle ERR to the owner, slave port quiet

module wishbone_rr_arbiter #(
    parameter int NUM_M     = 4,
    parameter int WB_ADDR_W = 32,
    parameter int WB_DATA_W = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                            CLK_I,
    input  logic                            RST_I,
    input  logic [NUM_M-1:0]                M_CYC_I,
    input  logic [NUM_M-1:0]                M_STB_I,
    input  logic [NUM_M-1:0]                M_WE_I,
    input  logic [NUM_M-1:0]                M_LOCK_I,
    input  logic [NUM_M*WB_ADDR_W-1:0]      M_ADR_I,
    input  logic [NUM_M*WB_DATA_W-1:0]      M_DAT_I,
    input  logic [NUM_M*(WB_DATA_W/8)-1:0]  M_SEL_I,
    input  logic [NUM_M*3-1:0]              M_CTI_I,
    input  logic [NUM_M*2-1:0]              M_BTE_I,
    output logic [WB_DATA_W-1:0]            M_DAT_O,
    output logic [NUM_M-1:0]                M_ACK_O,
    output logic [NUM_M-1:0]                M_ERR_O,
    output logic [NUM_M-1:0]                M_RTY_O,
    output logic                            S_CYC_O,
    output logic                            S_STB_O,
    output logic                            S_WE_O,
    output logic                            S_LOCK_O,
    output logic [WB_ADDR_W-1:0]            S_ADR_O,
    output logic [WB_DATA_W-1:0]            S_DAT_O,
    output logic [WB_DATA_W/8-1:0]          S_SEL_O,
    output logic [2:0]                      S_CTI_O,
    output logic [1:0]                      S_BTE_O,
    input  logic [WB_DATA_W-1:0]            S_DAT_I,
    input  logic                            S_ACK_I,
    input  logic                            S_ERR_I,
    input  logic                            S_RTY_I,
    output logic [NUM_M-1:0]                grant_o,
    output logic                            timeout_o
);

    localparam int SEL_W = WB_DATA_W / 8;
    localparam int PTR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // ptr_q is the current owner while granted and the last owner otherwise,
    // so one register serves both the mux select and the round-robin base.
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [9:0]       wdog_q, wdog_d;

    logic [NUM_M-1:0] own_oh;
    logic             own_cyc, own_stb, own_lock;
    logic             term, waiting, fire;

    logic [NUM_M-1:0] req;
    logic             pick_vld;
    logic [PTR_W-1:0] pick_idx;

    assign own_cyc  = M_CYC_I[ptr_q];
    assign own_stb  = M_STB_I[ptr_q];
    assign own_lock = M_LOCK_I[ptr_q];

    assign term    = S_ACK_I | S_ERR_I | S_RTY_I;
    assign waiting = (state_q == ST_GRANT) & own_cyc & own_stb & ~term;
    assign fire    = waiting & (wdog_q == WD_LAST);

    assign M_DAT_O = S_DAT_I;

    always_comb begin
        own_oh        = '0;
        own_oh[ptr_q] = 1'b1;
    end

    // Round-robin search starting just above ptr_q. The offset NUM_M (ptr_q
    // itself) is tried last, so the previous owner has lowest priority. While
    // granted the owner is masked out: at a release edge it must not re-win.
    always_comb begin
        int idx;
        idx      = 0;
        req      = M_CYC_I;
        if (state_q == ST_GRANT) begin
            req[ptr_q] = 1'b0;
        end
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NUM_M; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % NUM_M;
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_W'(NUM_M - 1);
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wdog_d    = '0;
        grant_o   = '0;
        timeout_o = 1'b0;
        M_ACK_O   = '0;
        M_ERR_O   = '0;
        M_RTY_O   = '0;
        S_CYC_O   = 1'b0;
        S_STB_O   = 1'b0;
        S_WE_O    = 1'b0;
        S_LOCK_O  = 1'b0;
        S_ADR_O   = '0;
        S_DAT_O   = '0;
        S_SEL_O   = '0;
        S_CTI_O   = '0;
        S_BTE_O   = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_GRANT;
                    ptr_d   = pick_idx;
                end
            end

            ST_GRANT: begin
                grant_o  = own_oh;
                S_CYC_O  = own_cyc;
                S_STB_O  = own_cyc & own_stb;
                S_WE_O   = M_WE_I[ptr_q];
                S_LOCK_O = own_lock;
                S_ADR_O  = M_ADR_I[int'(ptr_q)*WB_ADDR_W +: WB_ADDR_W];
                S_DAT_O  = M_DAT_I[int'(ptr_q)*WB_DATA_W +: WB_DATA_W];
                S_SEL_O  = M_SEL_I[int'(ptr_q)*SEL_W +: SEL_W];
                S_CTI_O  = M_CTI_I[int'(ptr_q)*3 +: 3];
                S_BTE_O  = M_BTE_I[int'(ptr_q)*2 +: 2];
                M_ACK_O  = S_ACK_I ? own_oh : '0;
                M_ERR_O  = S_ERR_I ? own_oh : '0;
                M_RTY_O  = S_RTY_I ? own_oh : '0;

                if (fire) begin
                    state_d = ST_TIMEOUT;
                end else if (!own_cyc && !own_lock) begin
                    // Hand over directly when someone else is waiting;
                    // otherwise ptr_q stays as the last owner.
                    if (pick_vld) begin
                        ptr_d = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (waiting) begin
                    wdog_d = wdog_q + 10'd1;
                end
            end

            ST_TIMEOUT: begin
                grant_o   = own_oh;
                M_ERR_O   = own_oh;
                timeout_o = 1'b1;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/wishbone_rr_arbiter.md
Name: wishbone_rr_arbiter

Overview:
- Shares one Wishbone B4 slave port between NUM_M bus masters (e.g. several traffic-generating masters in the UVC example system).
- Round-robin arbitration on CYC.
- Grant is held for a whole cycle/burst, and extended while the owner asserts LOCK.
- A per-grant watchdog terminates stalled transfers with ERR so one hung slave cannot lock the bus forever.

Parameters:
- NUM_M, 4, number of masters (2..8).
- WB_ADDR_W, 32, address width.
- WB_DATA_W, 32, data width; SEL width = WB_DATA_W/8.
- TIMEOUT, 255, cycles a granted STB may wait for ACK/ERR/RTY before the watchdog fires (1..1023).

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  reset; asynchronous, active-low
- M_CYC_I  in  NUM_M  per-master CYC
- M_STB_I  in  NUM_M  per-master STB
- M_WE_I  in  NUM_M  per-master WE
- M_LOCK_I  in  NUM_M  per-master LOCK
- M_ADR_I  in  NUM_M*WB_ADDR_W  packed addresses; master i at [i*W +: W]
- M_DAT_I  in  NUM_M*WB_DATA_W  packed write data
- M_SEL_I  in  NUM_M*WB_DATA_W/8  packed byte selects
- M_CTI_I  in  NUM_M*3  packed CTI
- M_BTE_I  in  NUM_M*2  packed BTE
- M_DAT_O  out  WB_DATA_W  read data, broadcast to all masters
- M_ACK_O  out  NUM_M  per-master ACK
- M_ERR_O  out  NUM_M  per-master ERR
- M_RTY_O  out  NUM_M  per-master RTY
- S_CYC_O, S_STB_O, S_WE_O, S_LOCK_O  out  1 each  to slave
- S_ADR_O  out  WB_ADDR_W  to slave
- S_DAT_O  out  WB_DATA_W  to slave
- S_SEL_O  out  WB_DATA_W/8  to slave
- S_CTI_O  out  3  to slave
- S_BTE_O  out  2  to slave
- S_DAT_I  in  WB_DATA_W  from slave
- S_ACK_I, S_ERR_I, S_RTY_I  in  1 each  from slave
- grant_o  out  NUM_M  one-hot current owner (debug/coverage)
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (RST_I low, async): state IDLE, grant_o=0, last-owner pointer = NUM_M-1, watchdog=0, timeout_o=0. All S_* outputs and all M_ACK/ERR/RTY_O are 0 combinationally.
- States:
  - IDLE: no owner. If any M_CYC_I is high, go to GRANT at the next edge, with grant = first requester searching upward (wrapping) from last+1. Arbitration latency is 1 cycle from CYC to S_CYC_O.
  - GRANT: S_* = the owner's signals (combinational mux gated by grant). Owner gets S_ACK_I/S_ERR_I/S_RTY_I on its M_*_O bits; all other masters see 0.
  - Leave GRANT when owner CYC=0 and owner LOCK=0. At that edge: last := owner.
    - If another master requests, grant it directly (no IDLE bubble).
    - Otherwise go to IDLE.
  - Owner CYC=0 with LOCK=1: keep grant, drive S_CYC_O=0, S_LOCK_O=1.
  - TIMEOUT: entered when the watchdog fires. Drive M_ERR_O[owner]=1 for exactly one cycle, S_STB_O=0, S_CYC_O=0; then go to IDLE with last := owner.
- Round-robin: the previous owner has lowest priority. With all NUM_M masters requesting continuously, grants go 0,1,2,3,0,… Each master is served within NUM_M-1 foreign tenures.
- Watchdog (10-bit counter):
  - Increments each GRANT cycle with S_STB_O=1 and no S_ACK/ERR/RTY.
  - Clears on any termination, on STB low, and on grant change.
  - Reaching TIMEOUT triggers the TIMEOUT state and a timeout_o pulse.
- Termination signals arriving during TIMEOUT or IDLE are ignored (not forwarded).
- Simultaneous release and new requests: the releasing master is excluded from the search that edge (its CYC is low anyway).
- Masters not granted are never acknowledged. They must hold CYC/STB until granted, per Wishbone.
- Reset mid-transfer: all outputs drop immediately; no partial termination is generated.

Test Plan:
- Single master 2 requests CYC for 3 ACKed beats (CTI 010, BTE 01), then drops CYC -> S_CYC_O high 1 cycle after M_CYC_I[2]; 3 M_ACK_O[2] pulses; grant returns to 0 one cycle after release.
- All 4 masters hold CYC, each performs 1 beat then drops CYC for one cycle -> grant_o sequence 0001,0010,0100,1000,0001 with no idle cycle between owners.
- Master 1 holds LOCK, drops CYC between two cycles while master 0 requests -> grant stays 0010 until LOCK=0; master 0 is granted the edge after.
- Slave never responds, TIMEOUT=16 -> M_ERR_O[owner] pulses 1 cycle after the 16th waiting cycle; timeout_o=1 that cycle; other queued master granted two cycles later.
- Slave returns RTY to master 3 and ERR to master 0 -> each routed only to its owner; M_DAT_O=S_DAT_I; non-owners see ACK/ERR/RTY=0.
- Assert RST_I low during master 2 burst -> S_CYC_O, grant_o, M_ACK_O zero immediately; after release, master 0 (if requesting) wins first.
